vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA/raster timing generator; next generation of the fixed 640x480 sync block.
- Generalised over resolution, porch and sync widths, sync polarity, pixel-clock divide ratio and pipeline alignment delay.
- Adds frame/line start strobes and a run/freeze enable.
- Sits between the system clock and the pixel renderer (pong objects, text overlay) that consumes x/y and returns colour N pixel ticks later.

Parameters:
- CLK_DIV, 4: system clocks per pixel tick, >=1.
- H_DISPLAY, 640: visible pixels per line.
- H_FRONT, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BACK, 48: horizontal back porch, in pixels.
- V_DISPLAY, 480: visible lines per frame.
- V_FRONT, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BACK, 33: vertical back porch, in lines.
- HSYNC_POL, 0: active level of hsync (0 = active low).
- VSYNC_POL, 0: active level of vsync.
- PIPE_DLY, 0: pixel ticks by which hsync/vsync/video_on lag x/y (0..7).
- CNT_W, 10: width of x/y; H_TOTAL-1 and V_TOTAL-1 must fit.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = run; 0 = freeze divider and counters.
- p_tick  out  1  one-clk pixel enable.
- x  out  CNT_W  horizontal count, 0..H_TOTAL-1.
- y  out  CNT_W  vertical count, 0..V_TOTAL-1.
- hsync  out  1  horizontal sync at HSYNC_POL, delayed PIPE_DLY ticks.
- vsync  out  1  vertical sync at VSYNC_POL, delayed PIPE_DLY ticks.
- video_on  out  1  visible-area flag, delayed PIPE_DLY ticks.
- line_start  out  1  one-clk pulse: p_tick && x==0.
- frame_start  out  1  one-clk pulse: p_tick && x==0 && y==0.

Behaviour:
- Derived totals:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (default 800).
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (default 525).
  - hsync window: x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1].
  - vsync window: y in [V_DISPLAY+V_FRONT, +V_SYNC-1].
- Reset values (async): divider=0, x=0, y=0, video_on=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL; delay line filled with inactive values.
- Pixel-tick divider:
  - Mod-CLK_DIV counter, advances only when enable=1.
  - p_tick = enable && div==0, so the first enabled clock after reset is a tick.
  - CLK_DIV=1: p_tick = enable.
- Counters, updated on clock edges where p_tick=1:
  - x==H_TOTAL-1 -> x=0, and y wraps (y==V_TOTAL-1 -> 0, else y+1).
  - Otherwise x+1, y unchanged.
- Raw decode is combinational from the current x/y: hs_raw = in hsync window, vs_raw = in vsync window, von_raw = x<H_DISPLAY && y<V_DISPLAY.
- Alignment:
  - PIPE_DLY=0: outputs are the raw decode with polarity applied (combinational, glitch-safe since x/y are flops).
  - PIPE_DLY=N>0: N-stage shift register of {hs,vs,von}, shifting only on p_tick. Outputs equal the decode of the x/y values present N ticks earlier.
  - Polarity is applied at the output: hsync = hs_d ^ ~HSYNC_POL (same form for vsync).
- enable=0:
  - divider, counters and delay line hold; p_tick, line_start and frame_start are 0.
  - Resuming continues from the held phase with no skipped or duplicated pixel.
- Reset mid-frame: immediate return to reset values. The first tick after release is frame_start at x=0,y=0.
- Strobes are combinational from p_tick and the current counters, i.e. asserted in the clock before the counter increments.
- Invalid parameters (CLK_DIV=0, totals exceeding CNT_W) are elaboration errors (generate-time check).

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480@60 default constants (display/porch/sync values, polarities);
  - a 800x600 constant set;
  - helper functions h_total/v_total for consumers sizing frame buffers.
- One natural sub-module: pixel_tick_div (divider plus enable gating, parameter CLK_DIV).
- The delay line stays inline.

Test Plan:
- Defaults, reset released with enable=1 -> p_tick on clocks 0,4,8,…; x reaches 799 then 0 with y=1 after 3200 clocks; frame_start recurs every 800*525*4=1,680,000 clocks.
- Defaults -> hsync low exactly for x=656..751 (96 ticks); vsync low for y=490..491; video_on high only for x<640, y<480.
- HSYNC_POL=1, VSYNC_POL=1, CLK_DIV=1 -> hsync high for x=656..751; p_tick constant 1; reset levels hsync=0, vsync=0.
- PIPE_DLY=3 -> video_on first falls three ticks after x becomes 640 (at x=643); hsync asserts at x=659; reset fills the delay line with inactive values.
- enable deasserted for 37 clocks at x=100 -> x, y and divider frozen, no strobes; on re-enable the next tick moves x to 101 at the expected phase.
- Reset asserted at x=300, y=200 -> outputs at reset values in the same cycle, asynchronously; after release frame_start is seen with x=0, y=0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and sizing helpers for the VGA timing generator
// and the consumers that size buffers from the same geometry.
package vga_timing_pkg;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative syncs
    localparam int  VGA640_H_DISPLAY = 640;
    localparam int  VGA640_H_FRONT   = 16;
    localparam int  VGA640_H_SYNC    = 96;
    localparam int  VGA640_H_BACK    = 48;
    localparam int  VGA640_V_DISPLAY = 480;
    localparam int  VGA640_V_FRONT   = 10;
    localparam int  VGA640_V_SYNC    = 2;
    localparam int  VGA640_V_BACK    = 33;
    localparam bit  VGA640_HSYNC_POL = 1'b0;
    localparam bit  VGA640_VSYNC_POL = 1'b0;

    // 800x600 @ 60 Hz, 40 MHz pixel clock, positive syncs (needs CNT_W >= 11)
    localparam int  SVGA800_H_DISPLAY = 800;
    localparam int  SVGA800_H_FRONT   = 40;
    localparam int  SVGA800_H_SYNC    = 128;
    localparam int  SVGA800_H_BACK    = 88;
    localparam int  SVGA800_V_DISPLAY = 600;
    localparam int  SVGA800_V_FRONT   = 1;
    localparam int  SVGA800_V_SYNC    = 4;
    localparam int  SVGA800_V_BACK    = 23;
    localparam bit  SVGA800_HSYNC_POL = 1'b1;
    localparam bit  SVGA800_VSYNC_POL = 1'b1;

    function automatic int h_total(input int display, input int front,
                                   input int sync, input int back);
        return display + front + sync + back;
    endfunction

    function automatic int v_total(input int display, input int front,
                                   input int sync, input int back);
        return display + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_tick_div.sv
// Pixel-tick divider: one-clock enable every CLK_DIV system clocks while running.
// The phase is held while enable is low so a resumed raster neither skips nor repeats.
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic p_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;

    // With CLK_DIV=1 the counter is pinned at zero and p_tick collapses to enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (enable) begin
            if (div == DIV_LAST) begin
                div <= '0;
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

    assign p_tick = enable && (div == '0);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel counters, sync/visible decode with
// selectable polarity, and a tick-aligned delay line matching the renderer latency.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = VGA640_H_DISPLAY,
    parameter int H_FRONT   = VGA640_H_FRONT,
    parameter int H_SYNC    = VGA640_H_SYNC,
    parameter int H_BACK    = VGA640_H_BACK,
    parameter int V_DISPLAY = VGA640_V_DISPLAY,
    parameter int V_FRONT   = VGA640_V_FRONT,
    parameter int V_SYNC    = VGA640_V_SYNC,
    parameter int V_BACK    = VGA640_V_BACK,
    parameter bit HSYNC_POL = VGA640_HSYNC_POL,
    parameter bit VSYNC_POL = VGA640_VSYNC_POL,
    parameter int PIPE_DLY  = 0,
    parameter int CNT_W     = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             p_tick,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_width
        $error("vga_timing_gen: H_TOTAL-1 or V_TOTAL-1 does not fit in CNT_W bits");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
        $error("vga_timing_gen: PIPE_DLY must be in 0..7");
    end

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic hs_raw;
    logic vs_raw;
    logic von_raw;
    logic hs_d;
    logic vs_d;
    logic von_d;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .p_tick (p_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (p_tick) begin
            if (x == H_LAST) begin
                x <= '0;
                if (y == V_LAST) begin
                    y <= '0;
                end else begin
                    y <= y + CNT_W'(1);
                end
            end else begin
                x <= x + CNT_W'(1);
            end
        end
    end

    always_comb begin
        hs_raw  = (x >= HS_FIRST) && (x <= HS_LAST);
        vs_raw  = (y >= VS_FIRST) && (y <= VS_LAST);
        von_raw = (x < H_VIS) && (y < V_VIS);
    end

    if (PIPE_DLY == 0) begin : g_no_dly
        assign hs_d  = hs_raw;
        assign vs_d  = vs_raw;
        // x/y=0 decodes as visible, so mask it to keep video_on low while held in reset
        assign von_d = von_raw & ~reset;
    end else begin : g_dly
        logic [2:0] dly [PIPE_DLY];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < PIPE_DLY; i++) begin
                    dly[i] <= 3'b000;
                end
            end else if (p_tick) begin
                dly[0] <= {hs_raw, vs_raw, von_raw};
                for (int i = 1; i < PIPE_DLY; i++) begin
                    dly[i] <= dly[i-1];
                end
            end
        end

        assign {hs_d, vs_d, von_d} = dly[PIPE_DLY-1];
    end

    assign hsync       = hs_d ^ ~HSYNC_POL;
    assign vsync       = vs_d ^ ~VSYNC_POL;
    assign video_on    = von_d;
    assign line_start  = p_tick && (x == '0);
    assign frame_start = p_tick && (x == '0) && (y == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken 24x13 raster: a divided, delayed,
// active-low instance and an undivided, undelayed, active-high instance side by side.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;

    logic       p_tick, hsync, vsync, video_on, line_start, frame_start;
    logic [5:0] x, y;
    logic       p_tick_p, hsync_p, vsync_p, video_on_p, line_start_p, frame_start_p;
    logic [5:0] x_p, y_p;

    int n_assert = 0;
    int n_fail   = 0;

    // H: 16 visible, sync x=18..20, total 24.  V: 8 visible, sync y=9..10, total 13.
    vga_timing_gen #(
        .CLK_DIV(4), .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_DLY(3), .CNT_W(6)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .p_tick(p_tick), .x(x), .y(y),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .line_start(line_start), .frame_start(frame_start)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE_DLY(0), .CNT_W(6)
    ) dut_p (
        .clk(clk), .reset(reset), .enable(enable), .p_tick(p_tick_p), .x(x_p), .y(y_p),
        .hsync(hsync_p), .vsync(vsync_p), .video_on(video_on_p),
        .line_start(line_start_p), .frame_start(frame_start_p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next_sample();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e_x = 0, e_y = 0, e_pt = 0, e_ls = 0, e_fs = 0, e_hs = 0, e_vs = 0, e_von = 0;
        int e_xp = 0, e_yp = 0, e_ptp = 0, e_lsp = 0, e_fsp = 0, e_hsp = 0, e_vsp = 0, e_vonp = 0;
        int e_frz = 0, e_frzp = 0;
        int kk, y_hold, xp_hold, yp_hold, waited;
        bit found;

        reset  = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_hsync_lo_pol", 32'(hsync), 1);
        chk("rst_vsync_lo_pol", 32'(vsync), 1);
        chk("rst_video_on", 32'(video_on), 0);
        chk("rst_hsync_hi_pol", 32'(hsync_p), 0);
        chk("rst_vsync_hi_pol", 32'(vsync_p), 0);
        chk("rst_video_on_p", 32'(video_on_p), 0);

        // Sample k sees k clock edges after release; dut ticks on edges 0,4,8,...
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int k = 0; k <= 2500; k++) begin
            int nt, mx, my, d, dx, dy, px, py;
            bit pt, ehs, evs, evon;
            nt = (k + 3) / 4;
            mx = nt % 24;
            my = (nt / 24) % 13;
            pt = (k % 4 == 0);
            if (nt >= 3) begin
                d    = nt - 3;
                dx   = d % 24;
                dy   = (d / 24) % 13;
                ehs  = !(dx >= 18 && dx <= 20);
                evs  = !(dy >= 9 && dy <= 10);
                evon = (dx < 16) && (dy < 8);
            end else begin
                ehs  = 1'b1;
                evs  = 1'b1;
                evon = 1'b0;
            end
            if (x !== 6'(mx)) e_x++;
            if (y !== 6'(my)) e_y++;
            if (p_tick !== pt) e_pt++;
            if (line_start !== (pt && mx == 0)) e_ls++;
            if (frame_start !== (pt && (nt % 312 == 0))) e_fs++;
            if (hsync !== ehs) e_hs++;
            if (vsync !== evs) e_vs++;
            if (video_on !== evon) e_von++;

            px = k % 24;
            py = (k / 24) % 13;
            if (x_p !== 6'(px)) e_xp++;
            if (y_p !== 6'(py)) e_yp++;
            if (p_tick_p !== 1'b1) e_ptp++;
            if (line_start_p !== (px == 0)) e_lsp++;
            if (frame_start_p !== (k % 312 == 0)) e_fsp++;
            if (hsync_p !== (px >= 18 && px <= 20)) e_hsp++;
            if (vsync_p !== (py >= 9 && py <= 10)) e_vsp++;
            if (video_on_p !== (px < 16 && py < 8)) e_vonp++;

            if (k == 0) begin
                chk("first_tick", 32'(p_tick), 1);
                chk("first_frame_start", 32'(frame_start), 1);
            end
            if (k == 72) chk("von_at_x18", 32'(video_on), 1);
            if (k == 76) chk("von_falls_x19", 32'(video_on), 0);
            if (k == 80) chk("hsync_idle_x20", 32'(hsync), 1);
            if (k == 84) chk("hsync_asserts_x21", 32'(hsync), 0);
            if (k == 92) chk("x_last", 32'(x), 23);
            if (k == 93) begin
                chk("x_wrap", 32'(x), 0);
                chk("y_inc", 32'(y), 1);
            end
            if (k == 96) chk("line_start_line1", 32'(line_start), 1);
            if (k == 1248) chk("frame_start_period", 32'(frame_start), 1);
            if (k == 17) chk("hsync_p_before", 32'(hsync_p), 0);
            if (k == 18) chk("hsync_p_first", 32'(hsync_p), 1);
            if (k == 21) chk("hsync_p_after", 32'(hsync_p), 0);
            next_sample();
        end
        chk("scan_x", e_x, 0);
        chk("scan_y", e_y, 0);
        chk("scan_p_tick", e_pt, 0);
        chk("scan_line_start", e_ls, 0);
        chk("scan_frame_start", e_fs, 0);
        chk("scan_hsync", e_hs, 0);
        chk("scan_vsync", e_vs, 0);
        chk("scan_video_on", e_von, 0);
        chk("scan_p_x", e_xp, 0);
        chk("scan_p_y", e_yp, 0);
        chk("scan_p_p_tick", e_ptp, 0);
        chk("scan_p_line_start", e_lsp, 0);
        chk("scan_p_frame_start", e_fsp, 0);
        chk("scan_p_hsync", e_hsp, 0);
        chk("scan_p_vsync", e_vsp, 0);
        chk("scan_p_video_on", e_vonp, 0);

        // Freeze with the divider two clocks into x=10
        kk = 2501;
        while (!((((kk + 3) / 4) % 24 == 10) && (kk % 4 == 2))) begin
            next_sample();
            kk++;
        end
        chk("pre_freeze_x", 32'(x), 10);
        y_hold  = (((kk + 3) / 4) / 24) % 13;
        xp_hold = kk % 24;
        yp_hold = (kk / 24) % 13;
        enable = 1'b0;
        #1;
        for (int i = 0; i < 37; i++) begin
            next_sample();
            if (p_tick !== 1'b0 || line_start !== 1'b0 || frame_start !== 1'b0) e_frz++;
            if (x !== 6'd10 || y !== 6'(y_hold)) e_frz++;
            if (p_tick_p !== 1'b0 || line_start_p !== 1'b0 || frame_start_p !== 1'b0) e_frzp++;
            if (x_p !== 6'(xp_hold) || y_p !== 6'(yp_hold)) e_frzp++;
        end
        chk("freeze_hold", e_frz, 0);
        chk("freeze_hold_p", e_frzp, 0);
        enable = 1'b1;
        #1;
        chk("resume_phase2_tick", 32'(p_tick), 0);
        chk("resume_p_tick_p", 32'(p_tick_p), 1);
        next_sample();
        chk("resume_phase3_tick", 32'(p_tick), 0);
        chk("resume_p_x_step", 32'(x_p), (xp_hold + 1) % 24);
        next_sample();
        chk("resume_phase0_tick", 32'(p_tick), 1);
        chk("resume_x_held", 32'(x), 10);
        next_sample();
        chk("resume_x_next", 32'(x), 11);

        // Reset in mid-frame must act before the next clock edge
        found  = 1'b0;
        waited = 0;
        while (!found && waited < 2000) begin
            if (x === 6'd7 && y === 6'd5) found = 1'b1;
            else begin
                next_sample();
                waited++;
            end
        end
        chk("wait_mid_frame", 32'(found), 1);
        reset = 1'b1;
        #1;
        chk("async_rst_x", 32'(x), 0);
        chk("async_rst_y", 32'(y), 0);
        chk("async_rst_hsync", 32'(hsync), 1);
        chk("async_rst_vsync", 32'(vsync), 1);
        chk("async_rst_video_on", 32'(video_on), 0);
        chk("async_rst_x_p", 32'(x_p), 0);
        chk("async_rst_video_on_p", 32'(video_on_p), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_frame_start", 32'(frame_start), 1);
        chk("post_rst_frame_start_p", 32'(frame_start_p), 1);
        chk("post_rst_y", 32'(y), 0);
        next_sample();
        chk("post_rst_x_step", 32'(x), 1);
        chk("post_rst_x_p_step", 32'(x_p), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
